// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate engine: streams activations, reads matching
// weights from a 1-cycle-latency memory, accumulates, adds bias, ReLU + saturate.
module neuron_mac #(
  parameter int numWeight = 784,
  parameter int addrWidth = 10,
  parameter int dataWidth = 16,
  parameter int fracBits  = 8,
  parameter int accWidth  = 2*dataWidth + addrWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [dataWidth-1:0] in_data,
  input  logic [dataWidth-1:0] bias,
  output logic                 ren,
  output logic [addrWidth-1:0] raddr,
  input  logic [dataWidth-1:0] win,
  output logic                 out_valid,
  output logic [dataWidth-1:0] out_data
);

  localparam int prodWidth = 2*dataWidth;

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  state_t                       state_reg, state_next;
  logic [addrWidth-1:0]         cnt_reg;
  logic                         v1_reg, l1_reg;
  logic [dataWidth-1:0]         d1_reg;
  logic                         v2_reg, l2_reg;
  logic [prodWidth-1:0]         p2_reg;
  logic signed [accWidth-1:0]   acc_reg;
  logic                         fin_reg;
  logic [dataWidth-1:0]         out_data_reg;

  logic                         accept;
  logic                         is_last;
  logic [prodWidth-1:0]         prod_next;
  logic signed [accWidth-1:0]   acc_next;
  logic signed [accWidth-1:0]   bias_scaled;
  logic signed [accWidth-1:0]   sum_next;
  logic signed [accWidth-1:0]   res_next;
  logic [dataWidth-1:0]         act_next;

  localparam logic signed [accWidth-1:0] maxPos =
    {{(accWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};

  assign in_ready  = (state_reg == ACC) && !rst;
  assign accept    = in_valid && in_ready;
  assign ren       = accept;
  assign raddr     = cnt_reg;
  assign is_last   = (cnt_reg == addrWidth'(numWeight - 1));
  assign out_valid = (state_reg == OUT);
  assign out_data  = out_data_reg;

  // Sign-extend both operands to full product width so the low bits are the signed product.
  assign prod_next = {{dataWidth{d1_reg[dataWidth-1]}}, d1_reg} *
                     {{dataWidth{win[dataWidth-1]}}, win};

  always_comb begin
    acc_next    = acc_reg + signed'({{(accWidth-prodWidth){p2_reg[prodWidth-1]}}, p2_reg});
    bias_scaled = signed'({{(accWidth-dataWidth){bias[dataWidth-1]}}, bias}) <<< fracBits;
    sum_next    = acc_next + bias_scaled;
    res_next    = sum_next >>> fracBits;
    act_next    = res_next[dataWidth-1:0];
    if (res_next[accWidth-1])
      act_next = '0;
    else if (res_next > maxPos)
      act_next = maxPos[dataWidth-1:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACC:     if (accept && is_last) state_next = DRAIN;
      DRAIN:   if (fin_reg)           state_next = OUT;
      OUT:                            state_next = ACC;
      default:                        state_next = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ACC;
      cnt_reg      <= '0;
      v1_reg       <= 1'b0;
      l1_reg       <= 1'b0;
      d1_reg       <= '0;
      v2_reg       <= 1'b0;
      l2_reg       <= 1'b0;
      p2_reg       <= '0;
      acc_reg      <= '0;
      fin_reg      <= 1'b0;
      out_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept)
        cnt_reg <= is_last ? '0 : cnt_reg + 1'b1;

      v1_reg <= accept;
      l1_reg <= accept && is_last;
      if (accept)
        d1_reg <= in_data;

      v2_reg <= v1_reg;
      l2_reg <= l1_reg;
      if (v1_reg)
        p2_reg <= prod_next;

      // fin_reg marks the cycle after the result landed, letting DRAIN hand over to OUT.
      fin_reg <= v2_reg && l2_reg;
      if (v2_reg) begin
        if (l2_reg) begin
          acc_reg      <= '0;
          out_data_reg <= act_next;
        end else begin
          acc_reg <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed + randomized bench for neuron_mac with numWeight=4; expected results
// come from an integer dot-product model of the fixed-point neuron.
module tb_neuron_mac;
  localparam int NW = 4;
  localparam int AW = 2;
  localparam int DW = 16;
  localparam int FB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] bias = '0;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] win = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;

  logic signed [DW-1:0] vin  [NW];
  logic signed [DW-1:0] wmem [NW];

  int total = 0;
  int bad   = 0;

  neuron_mac #(.numWeight(NW), .addrWidth(AW), .dataWidth(DW), .fracBits(FB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bias(bias), .ren(ren), .raddr(raddr), .win(win),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Weight memory with one-cycle registered read.
  always @(posedge clk) if (ren) win <= wmem[raddr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Real-valued neuron in integer form: floor((sum x*w + b*2^FB) / 2^FB), ReLU, saturate.
  function automatic logic [DW-1:0] ref_out();
    longint s = 0;
    for (int i = 0; i < NW; i++) s += longint'(vin[i]) * longint'(wmem[i]);
    s += longint'($signed(bias)) * (64'sd1 <<< FB);
    s = s >>> FB;
    if (s < 0) return '0;
    if (s > 32767) return 16'h7FFF;
    return DW'(s);
  endfunction

  task automatic send_samples(input int from, input int upto, input int gap_pct);
    int i = from;
    while (i < upto) begin
      @(negedge clk);
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        #1 chk("ren_gap", 64'(ren), 64'd0);
      end else begin
        in_valid = 1'b1;
        in_data  = vin[i];
        #1;
        chk("in_ready_acc", 64'(in_ready), 64'd1);
        chk("ren_acc", 64'(ren), 64'd1);
        chk("raddr", 64'(raddr), 64'(i));
        i++;
      end
    end
  endtask

  task automatic check_output(input string name);
    logic [DW-1:0] exp;
    exp = ref_out();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      #1;
      chk("in_ready_drain", 64'(in_ready), 64'd0);
      chk("ren_drain", 64'(ren), 64'd0);
      chk("out_valid_timing", 64'(out_valid), 64'(k == 4));
      if (k == 4) begin
        chk("out_data", 64'(out_data), 64'(exp));
        $display("vector %s: out_data=%h expected=%h", name, out_data, exp);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("in_ready_back", 64'(in_ready), 64'd1);
    chk("out_valid_pulse", 64'(out_valid), 64'd0);
    chk("out_data_hold", 64'(out_data), 64'(exp));
  endtask

  task automatic watch_no_output(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      #1 chk(tag, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    // Reset state, with in_valid asserted to prove nothing is accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_ren", 64'(ren), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // Unit weights: 1+2+3+4 = 10.0
    for (int i = 0; i < NW; i++) begin vin[i] = 16'(256 * (i + 1)); wmem[i] = 16'h0100; end
    bias = 16'h0000;
    chk("model_basic", 64'(ref_out()), 64'h0A00);
    send_samples(0, NW, 0);
    check_output("basic");

    // Negative weights: -10.0 + 1.0 clamps to 0
    for (int i = 0; i < NW; i++) wmem[i] = 16'hFF00;
    bias = 16'h0100;
    send_samples(0, NW, 0);
    check_output("relu");

    // Maximum magnitudes saturate without accumulator wrap
    for (int i = 0; i < NW; i++) begin vin[i] = 16'h7FFF; wmem[i] = 16'h7FFF; end
    bias = 16'h7FFF;
    send_samples(0, NW, 0);
    check_output("saturate");

    // 0.25 - 0.5 truncates to a negative value, clamped to 0
    for (int i = 0; i < NW; i++) begin vin[i] = 16'h0000; wmem[i] = 16'h0100; end
    vin[0] = 16'h0040;
    bias = 16'hFF80;
    send_samples(0, NW, 0);
    check_output("neg_trunc");

    // Back-to-back random vectors with gaps
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NW; i++) begin
        vin[i]  = 16'($urandom_range(0, 1023)) - 16'sd512;
        wmem[i] = 16'($urandom_range(0, 1023)) - 16'sd512;
      end
      bias = 16'($urandom_range(0, 2047)) - 16'd1024;
      send_samples(0, NW, 40);
      check_output($sformatf("rand%0d", v));
    end

    // Full-range random vectors
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NW; i++) begin vin[i] = 16'($urandom); wmem[i] = 16'($urandom); end
      bias = 16'($urandom);
      send_samples(0, NW, 25);
      check_output($sformatf("wide%0d", v));
    end

    // Reset after 2 of 4 samples: aborted vector must produce nothing
    for (int i = 0; i < NW; i++) begin vin[i] = 16'h0200; wmem[i] = 16'h0300; end
    bias = 16'h0000;
    send_samples(0, 2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_ren", 64'(ren), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    watch_no_output("midrst_no_out", 6);
    for (int i = 0; i < NW; i++) begin vin[i] = 16'(64 * (i + 1)); wmem[i] = 16'h0180; end
    bias = 16'h0040;
    send_samples(0, NW, 0);
    check_output("after_rst");

    // Reset right after the last accept suppresses the result
    send_samples(0, NW, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    watch_no_output("lastrst_no_out", 6);
    send_samples(0, NW, 20);
    check_output("after_lastrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate engine and the read-side master of one weight memory. It accepts a stream of `numWeight` input activations, issues one weight read per accepted sample, and multiplies each sample by its weight. It accumulates the products, adds a bias, applies ReLU with saturation, and emits one activation per input vector. One instance sits per neuron in a layer, directly wired to that neuron's weight memory (1-cycle registered read latency).

## Interface
- `numWeight`, 784: inputs per vector, equal to the attached weight memory depth.
- `addrWidth`, 10: weight address width; 2^addrWidth >= numWeight.
- `dataWidth`, 16: width of activations, weights and bias; signed two's complement.
- `fracBits`, 8: fractional bits of the shared fixed-point format.
- `accWidth`, 2*dataWidth+addrWidth: signed accumulator width; must not overflow over numWeight products.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` valid this cycle.
- `in_ready` out 1: block can accept a sample this cycle.
- `in_data` in dataWidth: input activation, signed.
- `bias` in dataWidth: neuron bias, signed, held stable by the parent.
- `ren` out 1: weight memory read enable.
- `raddr` out addrWidth: weight memory read address.
- `win` in dataWidth: weight memory output; valid the cycle after `ren`.
- `out_valid` out 1: one-cycle pulse, `out_data` valid.
- `out_data` out dataWidth: activation result, signed, always >= 0.

## Operation
- Sample accept occurs when `in_valid & in_ready`. `ren` is combinational and equals accept. `raddr` equals the registered sample counter `cnt`, which is 0..numWeight-1.
- Each accept increments `cnt`. Accepting sample index numWeight-1 wraps `cnt` to 0 and sets the `last` tag that travels down the pipeline.
- Stage 1 registers `in_data` plus valid/last. Stage 2 registers the signed product `d1 * win` (2*dataWidth bits, 2*fracBits fractional) plus valid/last. Stage 3 adds the product into `acc`, with the product sign-extended to accWidth.
- Finalize runs on the stage-3 update carrying `last`:
  - Form `sum = acc_final + (sign-extended bias <<< fracBits)`.
  - Compute `res = sum >>> fracBits` (arithmetic shift, truncation toward −inf).
  - ReLU: if `res < 0`, output 0.
  - Saturate: if `res > 2^(dataWidth-1)-1`, output 2^(dataWidth-1)-1.
  - Register the result into `out_data` and pulse `out_valid`.
  - Clear `acc` to 0 in the same edge.
- States:
  - ACC: `in_ready`=1. On accept of the last sample, go to DRAIN.
  - DRAIN: `in_ready`=0. Wait until finalize has registered, then go to OUT.
  - OUT: `in_ready`=0, `out_valid`=1 for one cycle. Next state is ACC.
- Gaps in `in_valid` are allowed anywhere within a vector. Bubbles propagate through the stage valids and do not touch `acc`.
- `out_data` holds its value after the `out_valid` pulse until the next finalize.
- There is no output backpressure; the parent must consume `out_valid` when it pulses.

## Timing
- If a sample is accepted in cycle t, `ren`=1 and `raddr`=index in cycle t, `win` is valid in cycle t+1, the product registers at the end of t+1, and `acc` updates at the end of t+2.
- If the last sample is accepted in cycle T, `out_valid`=1 in cycle T+4, `in_ready`=0 in cycles T+1..T+4, and `in_ready`=1 again in T+5.
- Throughput: one sample per cycle sustained. Minimum vector period is numWeight+4 cycles.
- Reset values:
  - State is ACC, `cnt`=0, `acc`=0, all stage valid/last flags are 0.
  - `out_valid`=0, `out_data`=0.
  - `in_ready`=0 and `ren`=0 while `rst`=1.
- Reset mid-vector discards all partial work. The first accept after `rst` falls reads address 0.
- `rst` asserted in the same cycle as a last-sample accept suppresses the output; no `out_valid` follows.

## Test plan
- With numWeight=4, fracBits=8 and all weights 0x0100, stream inputs 0x0100, 0x0200, 0x0300, 0x0400 with bias 0. Required: `raddr` sequence 0,1,2,3 with `ren`=1 each cycle, and `out_data`=0x0A00 with `out_valid` exactly 4 cycles after the last accept.
- Same stream with weights 0xFF00 (−1.0) and bias 0x0100. Required: `out_data`=0x0000 (ReLU clamp).
- Inputs and weights all 0x7FFF with bias 0x7FFF. Required: `out_data`=0x7FFF (saturation); `acc` shows no wrap.
- Two vectors back-to-back with random `in_valid` gaps. Required: `in_ready` low for exactly 4 cycles after each last accept, the second result is independent of the first (`acc` cleared), and the address restarts at 0.
- Assert `rst` after 2 of 4 samples, then stream a full vector. Required: no `out_valid` from the aborted vector; the new vector reads from address 0 and produces the correct result.
- Bias 0xFF80 (−0.5) with a dot product of 0x0040 (0.25). Required: `out_data`=0 (negative sum after arithmetic truncation, clamped by ReLU).
